// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch front end. Issues one instruction-memory
//            request at a time and buffers completed fetches (or misaligned-
//            fetch faults) in a circular FIFO presented to decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          QDEPTH    = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] pc_addr,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_fault
);

  localparam int                C_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int                C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(QDEPTH);

  // IDLE: nothing outstanding; WAIT: outstanding, result kept;
  // DRAIN: outstanding, result will be thrown away (flushed while waiting).
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [C_CNT_W-1:0]   count_q, count_d;
  logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                 imem_req_q, imem_req_d;
  logic [31:0]          imem_addr_q, imem_addr_d;

  logic [31:0]          instr_mem_q [QDEPTH];
  logic [31:0]          pc_mem_q    [QDEPTH];
  logic                 fault_mem_q [QDEPTH];

  logic                 accept;
  logic                 aligned;
  logic                 enq_fault;
  logic                 enq_mem;
  logic                 enq;
  logic                 deq;
  logic [31:0]          wr_instr;
  logic [31:0]          wr_pc;
  logic                 wr_fault;

  // Slot for the pending fetch is implicitly reserved: a new address is only
  // accepted in IDLE with room left, and only one request is ever in flight.
  assign pc_ready  = (state_q == S_IDLE) && !flush && (count_q < C_FULL);
  assign accept    = pc_valid && pc_ready;
  assign aligned   = (pc_addr[1:0] == 2'b00);
  assign enq_fault = accept && !aligned;
  assign enq       = enq_fault || enq_mem;

  assign id_valid  = (count_q != '0) && !flush;
  assign deq       = id_valid && id_ready;

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  // Fault entries carry the NOP word; memory entries carry fetched data.
  assign wr_instr  = enq_fault ? NOP_INSTR : imem_rdata;
  assign wr_pc     = enq_fault ? pc_addr   : imem_addr_q;
  assign wr_fault  = enq_fault;

  // Head of queue, or the fixed empty-queue values.
  always_comb begin
    id_instr = NOP_INSTR;
    id_pc    = 32'h0000_0000;
    id_fault = 1'b0;
    if (count_q != '0) begin
      id_instr = instr_mem_q[rd_ptr_q];
      id_pc    = pc_mem_q[rd_ptr_q];
      id_fault = fault_mem_q[rd_ptr_q];
    end
  end

  // pc+4 wraps naturally in 32 bits; empty queue gives 0+4 = 4.
  assign id_pc_plus4 = id_pc + 32'd4;

  // Request FSM next state: issue, wait for ack, or drain a flushed request.
  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    enq_mem     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && aligned) begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc_addr;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = S_IDLE;
          enq_mem    = !flush;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  // Queue pointer/occupancy next state; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + C_CNT_W'(1);
        2'b01:   count_d = count_q - C_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  // Entry storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      instr_mem_q[wr_ptr_q] <= wr_instr;
      pc_mem_q[wr_ptr_q]    <= wr_pc;
      fault_mem_q[wr_ptr_q] <= wr_fault;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue: directed vector table,
//            hand-written corner sequences and randomized traffic against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int QD = 4;

  logic        clk;
  logic        rest;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_fault;

  fetch_queue #(.QDEPTH(QD), .NOP_INSTR(32'h0000_0000)) dut (
    .clk        (clk),
    .rest       (rest),
    .pc_addr    (pc_addr),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_fault   (id_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy;
  bit          m_keep;
  logic [31:0] m_addr;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_keep = 1'b0;
    m_addr = 32'h0;
  endtask

  function automatic bit m_pc_ready();
    return !m_busy && !flush && (mq.size() < QD);
  endfunction

  task automatic model_check();
    logic [31:0] e_instr, e_pc;
    logic        e_f;
    if (mq.size() == 0) begin
      e_instr = 32'h0; e_pc = 32'h0; e_f = 1'b0;
    end else begin
      e_instr = mq[0].instr; e_pc = mq[0].pc; e_f = mq[0].fault;
    end
    chk("m_pc_ready",  32'(pc_ready),  32'(m_pc_ready()));
    chk("m_id_valid",  32'(id_valid),  32'((mq.size() != 0) && !flush));
    chk("m_imem_req",  32'(imem_req),  32'(m_busy));
    chk("m_imem_addr", imem_addr,      m_addr);
    chk("m_id_instr",  id_instr,       e_instr);
    chk("m_id_pc",     id_pc,          e_pc);
    chk("m_id_pc4",    id_pc_plus4,    e_pc + 32'd4);
    chk("m_id_fault",  32'(id_fault),  32'(e_f));
  endtask

  task automatic model_edge();
    bit deq, acc;
    deq = (mq.size() != 0) && !flush && id_ready;
    acc = pc_valid && m_pc_ready();
    if (flush) begin
      mq.delete();
      if (m_busy) begin
        if (imem_ack) m_busy = 1'b0;
        else          m_keep = 1'b0;
      end
    end else begin
      if (deq) void'(mq.pop_front());
      if (m_busy && imem_ack) begin
        if (m_keep) mq.push_back('{instr: imem_rdata, pc: m_addr, fault: 1'b0});
        m_busy = 1'b0;
      end
      if (acc) begin
        if (pc_addr[1:0] == 2'b00) begin
          m_busy = 1'b1; m_keep = 1'b1; m_addr = pc_addr;
        end else begin
          mq.push_back('{instr: 32'h0, pc: pc_addr, fault: 1'b1});
        end
      end
    end
  endtask

  // check at negedge, then move model across the rising edge
  task automatic sample_model();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    if (rest) model_edge();
    else      model_reset();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic fl,
                       input logic ak, input logic [31:0] rd, input logic rdy);
    pc_valid = v; pc_addr = a; flush = fl; imem_ack = ak; imem_rdata = rd; id_ready = rdy;
  endtask

  task automatic cyc();
    sample_model();
    advance();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic        fl;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_prdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic        e_f;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // vld addr fl ack rdata rdy | prdy req imem_addr vld instr pc pc4 fault
    tbl[0]  = '{1'b1, 32'h40,       1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h2408_0005, 1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h40,       1'b1, 32'h2408_0005, 32'h40,       32'h44, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h40,       1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[4]  = '{1'b1, 32'h42,       1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h40,       1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h40,       1'b1, 32'h0,        32'h42,       32'h46, 1'b1};
    tbl[6]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h40,       1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h13,       1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h13,       32'hFFFF_FFFC, 32'h0,  1'b0};
    tbl[9]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[11] = '{1'b1, 32'h200,      1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[12] = '{1'b1, 32'h200,      1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'h4,  1'b0};
    tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h100,      1'b0, 32'h0,        32'h0,        32'h4,  1'b0};

    // ---- reset ----
    rest = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    model_reset();
    sample_model();
    chk("rst_pc_ready", 32'(pc_ready), 32'h1);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    @(posedge clk); #1;
    rest = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].vld, tbl[i].addr, tbl[i].fl, tbl[i].ack, tbl[i].rdata, tbl[i].rdy);
      sample_model();
      chk($sformatf("t%0d_pc_ready", i),  32'(pc_ready), 32'(tbl[i].e_prdy));
      chk($sformatf("t%0d_imem_req", i),  32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("t%0d_imem_addr", i), imem_addr,     tbl[i].e_addr);
      chk($sformatf("t%0d_id_valid", i),  32'(id_valid), 32'(tbl[i].e_vld));
      chk($sformatf("t%0d_id_instr", i),  id_instr,      tbl[i].e_instr);
      chk($sformatf("t%0d_id_pc", i),     id_pc,         tbl[i].e_pc);
      chk($sformatf("t%0d_id_pc4", i),    id_pc_plus4,   tbl[i].e_pc4);
      chk($sformatf("t%0d_id_fault", i),  32'(id_fault), 32'(tbl[i].e_f));
      advance();
    end

    // ---- fill queue to depth with decode stalled ----
    for (int k = 0; k < QD; k++) begin
      drive(1'b1, 32'h1000 + 32'(4 * k), 1'b0, 1'b0, 32'h0, 1'b0);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hA0 + 32'(k), 1'b0);
      cyc();
    end
    drive(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b0);
    sample_model();
    chk("full_pc_ready", 32'(pc_ready), 32'h0);
    chk("full_head_pc",  id_pc,         32'h1000);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    sample_model();
    chk("after_pop_pc_ready", 32'(pc_ready), 32'h1);
    advance();
    for (int k = 1; k < QD; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      sample_model();
      chk($sformatf("order%0d_pc", k),    id_pc,    32'h1000 + 32'(4 * k));
      chk($sformatf("order%0d_instr", k), id_instr, 32'hA0 + 32'(k));
      advance();
    end

    // ---- asynchronous reset while a request is outstanding ----
    drive(1'b1, 32'h301, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    drive(1'b1, 32'h302, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    drive(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_imem_req", 32'(imem_req), 32'h1);
    chk("pre_rst_id_valid", 32'(id_valid), 32'h1);
    rest = 1'b0;
    #1;
    chk("async_rst_imem_req", 32'(imem_req), 32'h0);
    chk("async_rst_id_valid", 32'(id_valid), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rest = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample_model();
    chk("late_ack_id_valid", 32'(id_valid), 32'h0);
    advance();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      a = $urandom();
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      drive($urandom_range(1) == 1, a, $urandom_range(19) == 0,
            $urandom_range(9) < 4, $urandom(), $urandom_range(2) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter QDEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word presented on id_instr when queue empty or on fault entries.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rest  input  1  reset, asynchronous, active-low.
REQ-005 pc_addr  input  32  fetch address from program counter.
REQ-006 pc_valid  input  1  pc_addr valid this cycle.
REQ-007 pc_ready  output  1  fetch_queue accepts pc_addr at this edge.
REQ-008 flush  input  1  redirect; discards queued and in-flight fetches.
REQ-009 imem_req  output  1  instruction memory request, registered.
REQ-010 imem_addr  output  32  word address of request, registered.
REQ-011 imem_ack  input  1  memory completes request at this edge; imem_rdata valid.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 id_valid  output  1  head entry valid toward decode.
REQ-014 id_ready  input  1  decode consumes head at this edge.
REQ-015 id_instr / id_pc / id_pc_plus4  output  32 each  head instruction, its address, address+4.
REQ-016 id_fault  output  1  head entry is a misaligned-fetch fault.

Function
REQ-017 FSM states: IDLE (no request outstanding), WAIT (request outstanding, result kept), DRAIN (request outstanding, result discarded).
REQ-018 pc_ready = (state==IDLE) && !flush && (count < QDEPTH); combinational from registered state/count and flush.
REQ-019 Accept = pc_valid && pc_ready at rising edge.
REQ-020 Accept with pc_addr[1:0]==0: imem_req<=1, imem_addr<=pc_addr, state<=WAIT; no queue write that edge.
REQ-021 Accept with pc_addr[1:0]!=0: no memory request; enqueue {NOP_INSTR, pc_addr, pc_addr+4, fault=1} at that edge; state stays IDLE.
REQ-022 imem_req and imem_addr SHALL hold stable from issue until the edge with imem_ack=1; imem_ack ignored when imem_req=0.
REQ-023 WAIT with imem_ack=1 and flush=0: enqueue {imem_rdata, imem_addr, imem_addr+4, fault=0}, imem_req<=0, state<=IDLE.
REQ-024 Latency: accept edge N -> imem_req high cycle N+1; zero-wait ack at edge N+1 -> id_valid high cycle N+2 (queue previously empty).
REQ-025 Max one request outstanding; queue write cannot overflow because pc_ready requires count<QDEPTH and entry slot is reserved until result/fault enqueued.
REQ-026 Queue: circular FIFO, wr/rd pointers wrap mod QDEPTH, count 0..QDEPTH; enqueue+dequeue same edge leaves count unchanged.
REQ-027 id_valid = (count!=0) && !flush; dequeue = id_valid && id_ready.
REQ-028 Empty queue: id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=4, id_fault=0.
REQ-029 Address arithmetic 32-bit modulo; 32'hFFFF_FFFC yields id_pc_plus4=0.
REQ-030 flush at edge: count<=0, pointers<=0, no accept, no dequeue; overrides all same-edge enqueues.
REQ-031 flush in WAIT with imem_ack=1: data discarded, imem_req<=0, state<=IDLE.
REQ-032 flush in WAIT with imem_ack=0: state<=DRAIN, imem_req stays 1.
REQ-033 DRAIN: on imem_ack=1 discard data, imem_req<=0, state<=IDLE; flush in DRAIN has no further effect.

Reset
REQ-034 rest low asynchronously forces: state IDLE, count 0, pointers 0, imem_req 0, imem_addr 0; hence id_valid 0, pc_ready 1 once flush=0 (outputs per REQ-028).
REQ-035 Reset mid-request abandons it; any later imem_ack while imem_req=0 is ignored.

Verification
REQ-036 Reset release, pc_addr=0x0000_0040 valid, zero-wait ack rdata=0x2408_0005 -> imem_req cycle 1, id_valid cycle 2 with id_instr=0x2408_0005, id_pc=0x40, id_pc_plus4=0x44.
REQ-037 id_ready=0, four aligned fetches, QDEPTH=4 -> count 4, pc_ready=0; single id_ready pulse -> pc_ready returns 1, order preserved.
REQ-038 pc_addr=0x0000_0042 -> no imem_req; next cycle id_valid=1, id_fault=1, id_instr=0x0000_0000, id_pc_plus4=0x46.
REQ-039 Request at 0x100 with ack delayed 3 cycles, flush in cycle 1 -> DRAIN, imem_req held, ack discarded, queue empty, pc_ready 1 the cycle after ack.
REQ-040 rest asserted while WAIT with 2 queued entries -> imem_req, id_valid 0 immediately without clock edge; late imem_ack produces no entry.
REQ-041 Fetch at 0xFFFF_FFFC -> id_pc_plus4=0x0000_0000.
